// File: rtl/demux4_1_2_buf.sv
// rtl/demux4_1_2_buf.sv - buffered 1-to-2 demultiplexer with per-channel FIFOs
// Each input word is steered by in_sel into one of two FIFOs that drain independently.
module demux4_1_2_buf #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_sel,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           out0_data,
    output logic                       out0_valid,
    input  logic                       out0_ready,
    output logic [WIDTH-1:0]           out1_data,
    output logic                       out1_valid,
    input  logic                       out1_ready,
    output logic [$clog2(DEPTH):0]     occ0,
    output logic [$clog2(DEPTH):0]     occ1,
    output logic [CNT_W-1:0]           cnt0,
    output logic [CNT_W-1:0]           cnt1
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL = OW'(DEPTH);

    logic [WIDTH-1:0] r_mem [2][DEPTH];
    logic [PW-1:0]    r_wp  [2];
    logic [PW-1:0]    r_rp  [2];
    logic [OW-1:0]    r_occ [2];
    logic [CNT_W-1:0] r_cnt [2];

    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_valid;
    logic [1:0] w_oready;

    // Acceptance looks only at the selected channel, so a full channel never blocks the other.
    assign in_ready  = !rst && (r_occ[in_sel] != FULL);
    assign w_push[0] = in_valid && in_ready && !in_sel;
    assign w_push[1] = in_valid && in_ready &&  in_sel;

    assign w_valid[0] = (r_occ[0] != '0);
    assign w_valid[1] = (r_occ[1] != '0);
    assign w_oready   = {out1_ready, out0_ready};
    assign w_pop      = w_valid & w_oready;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                r_wp[c]  <= '0;
                r_rp[c]  <= '0;
                r_occ[c] <= '0;
                r_cnt[c] <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[c][e] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (w_push[c]) begin
                    r_mem[c][r_wp[c]] <= in_data;
                    r_wp[c]           <= r_wp[c] + 1'b1;
                end
                if (w_pop[c]) begin
                    r_rp[c]  <= r_rp[c] + 1'b1;
                    r_cnt[c] <= r_cnt[c] + 1'b1;
                end
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_occ[c] <= r_occ[c] + 1'b1;
                    2'b01:   r_occ[c] <= r_occ[c] - 1'b1;
                    default: r_occ[c] <= r_occ[c];
                endcase
            end
        end
    end

    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out0_data  = r_mem[0][r_rp[0]];
    assign out1_data  = r_mem[1][r_rp[1]];
    assign occ0       = r_occ[0];
    assign occ1       = r_occ[1];
    assign cnt0       = r_cnt[0];
    assign cnt1       = r_cnt[1];

endmodule

// File: tb/tb_demux4_1_2_buf.sv
// tb/tb_demux4_1_2_buf.sv - scoreboard bench for demux4_1_2_buf
module tb_demux4_1_2_buf;
    logic       clk = 0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [3:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
    logic [1:0] occ0;
    logic [1:0] occ1;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int n_chk  = 0;
    int n_fail = 0;
    logic [3:0] q0[$];
    logic [3:0] q1[$];

    demux4_1_2_buf #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
        .out0_data(out0_data), .out0_valid(out0_valid), .out0_ready(out0_ready),
        .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
        .occ0(occ0), .occ1(occ1), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake on an output channel must match the head of its expected queue.
    always @(negedge clk) begin
        if (!rst && out0_valid && out0_ready) begin
            if (q0.size() == 0) chk("ch0_unexpected", {28'h0, out0_data}, 32'hFFFF_FFFF);
            else chk("ch0_data", {28'h0, out0_data}, {28'h0, q0.pop_front()});
        end
        if (!rst && out1_valid && out1_ready) begin
            if (q1.size() == 0) chk("ch1_unexpected", {28'h0, out1_data}, 32'hFFFF_FFFF);
            else chk("ch1_data", {28'h0, out1_data}, {28'h0, q1.pop_front()});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic s);
        in_data  = d;
        in_sel   = s;
        in_valid = 1'b1;
        if (s) q1.push_back(d);
        else   q0.push_back(d);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        q0.delete();
        q1.delete();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_data = '0; in_sel = 1'b0; in_valid = 1'b0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {31'h0, in_ready}, 0);
        chk("rst_valid0", {31'h0, out0_valid}, 0);
        chk("rst_valid1", {31'h0, out1_valid}, 0);
        chk("rst_occ", {28'h0, occ1, occ0}, 0);
        chk("rst_cnt", {16'h0, cnt1, cnt0}, 0);
        chk("rst_data", {24'h0, out1_data, out0_data}, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 1);

        // single route
        push(4'hA, 1'b0);
        chk("route_valid0", {31'h0, out0_valid}, 1);
        chk("route_data0", {28'h0, out0_data}, 32'hA);
        chk("route_occ0", {30'h0, occ0}, 1);
        chk("route_valid1", {31'h0, out1_valid}, 0);
        out0_ready = 1'b1;
        tick();
        out0_ready = 1'b0;
        chk("route_occ0_drained", {30'h0, occ0}, 0);
        chk("route_cnt0", {24'h0, cnt0}, 1);

        // fill channel 1 and check isolation
        push(4'h3, 1'b1);
        push(4'h5, 1'b1);
        chk("fill_occ1", {30'h0, occ1}, 2);
        in_sel = 1'b1;
        #1;
        chk("full_in_ready_sel1", {31'h0, in_ready}, 0);
        in_sel = 1'b0;
        #1;
        chk("full_in_ready_sel0", {31'h0, in_ready}, 1);
        push(4'h7, 1'b0);
        chk("iso_occ0", {30'h0, occ0}, 1);
        chk("iso_occ1", {30'h0, occ1}, 2);
        chk("iso_head1", {28'h0, out1_data}, 32'h3);
        out0_ready = 1'b1;
        tick();
        out0_ready = 1'b0;

        // full channel with simultaneous pop: push refused, retried next cycle
        in_data = 4'h9; in_sel = 1'b1; in_valid = 1'b1; out1_ready = 1'b1;
        #1;
        chk("full_pop_in_ready", {31'h0, in_ready}, 0);
        tick();
        chk("full_pop_occ1", {30'h0, occ1}, 1);
        chk("retry_in_ready", {31'h0, in_ready}, 1);
        q1.push_back(4'h9);
        tick();
        in_valid = 1'b0;
        chk("retry_occ1", {30'h0, occ1}, 1);
        tick();
        out1_ready = 1'b0;
        chk("retry_occ1_empty", {30'h0, occ1}, 0);
        chk("retry_cnt1", {24'h0, cnt1}, 3);

        // streaming with pointer wrap
        do_reset();
        out0_ready = 1'b1; out1_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 4'(i); in_sel = i[0]; in_valid = 1'b1;
            #1;
            chk("stream_in_ready", {31'h0, in_ready}, 1);
            if (i[0]) q1.push_back(4'(i));
            else      q0.push_back(4'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("stream_cnt0", {24'h0, cnt0}, 8);
        chk("stream_cnt1", {24'h0, cnt1}, 8);
        chk("stream_occ", {28'h0, occ1, occ0}, 0);
        out0_ready = 1'b0; out1_ready = 1'b0;

        // reset mid-operation discards buffered words
        push(4'h1, 1'b0);
        push(4'h2, 1'b0);
        chk("mid_occ0", {30'h0, occ0}, 2);
        do_reset();
        chk("mid_rst_occ0", {30'h0, occ0}, 0);
        chk("mid_rst_valid0", {31'h0, out0_valid}, 0);
        out0_ready = 1'b1;
        tick();
        tick();
        chk("mid_rst_cnt0", {24'h0, cnt0}, 0);

        // counter wrap after 256 deliveries
        for (int i = 0; i < 256; i++) begin
            in_data = 4'(i); in_sel = 1'b0; in_valid = 1'b1;
            q0.push_back(4'(i));
            tick();
        end
        in_valid = 1'b0;
        chk("wrap_cnt0_255", {24'h0, cnt0}, 255);
        tick();
        chk("wrap_cnt0_0", {24'h0, cnt0}, 0);
        chk("wrap_occ0", {30'h0, occ0}, 0);
        out0_ready = 1'b0;
        tick();

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
